// File: rtl/mc_control_unit.sv
// Multicycle control unit for the 16-bit datapath: fetch/decode/execute sequencing with
// a request/ready memory handshake, wait-state watchdog, illegal-opcode fault and halt/resume.
module mc_control_unit #(
    parameter int WIDTH     = 16,
    parameter int REGBITS   = 4,
    parameter int TIMEOUT   = 15,
    parameter int TCNT_BITS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opCode1,
    input  logic [3:0] opCode2,
    input  logic [3:0] condCode,
    input  logic [4:0] psr,
    input  logic       mem_ready,
    input  logic       halt,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_load,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic [3:0] alu_ctrl,
    output logic [3:0] shift_ctrl,
    output logic       srcb_imm,
    output logic       zero_ext,
    output logic [1:0] result_sel,
    output logic       result_en,
    output logic       psr_en,
    output logic       reg_we,
    output logic       instr_done,
    output logic       halted,
    output logic       fault,
    output logic [4:0] state_o
);

    typedef enum logic [4:0] {
        FETCH   = 5'h00, DECODE  = 5'h01, ITYPEEX = 5'h02, RTYPEEX = 5'h03,
        SHIFTEX = 5'h04, ALUWR   = 5'h05, MEMADR  = 5'h06, LDRD    = 5'h07,
        LDWR    = 5'h08, STWR    = 5'h09, BCONDEX = 5'h0A, JALEX   = 5'h0B,
        JALWR   = 5'h0C, JCONDEX = 5'h0D, HALT    = 5'h0E, FAULT   = 5'h0F
    } state_t;

    // The watchdog fires on the TIMEOUT-th consecutive wait cycle, i.e. when the count is TIMEOUT-1.
    localparam logic [TCNT_BITS-1:0] WAIT_LIMIT = TCNT_BITS'(TIMEOUT - 1);

    if ((TIMEOUT >= (1 << TCNT_BITS)) || (WIDTH != (1 << $clog2(WIDTH))) || (REGBITS < 1)) begin : gBadCfg
        $error("mc_control_unit: invalid parameter set");
    end

    state_t               state_r;
    logic [TCNT_BITS-1:0] waitCnt_r;
    logic                 memPhase_s;
    logic                 timeout_s;
    logic                 pass_s;
    logic                 isCmp_s;
    state_t               boundary_s;

    function automatic logic condPass(input logic [3:0] cc, input logic [4:0] flags);
        logic z, c, f, l, n;
        {z, c, f, l, n} = flags;
        case (cc)
            4'h0:    condPass = z;
            4'h1:    condPass = !z;
            4'h2:    condPass = c;
            4'h3:    condPass = !c;
            4'h4:    condPass = n;
            4'h5:    condPass = !n;
            4'h6:    condPass = l;
            4'h7:    condPass = !l;
            4'h8:    condPass = f;
            4'h9:    condPass = !f;
            4'hA:    condPass = !z && !n;
            4'hB:    condPass = z || n;
            4'hC:    condPass = !l && !z;
            4'hD:    condPass = z || l;
            4'hE:    condPass = 1'b1;
            default: condPass = 1'b0;
        endcase
    endfunction

    // Shared decode terms: memory phase, watchdog expiry, branch condition, compare, boundary target.
    always_comb begin
        memPhase_s = (state_r == FETCH) || (state_r == LDRD) || (state_r == STWR);
        timeout_s  = (TIMEOUT != 0) && (waitCnt_r == WAIT_LIMIT) && !mem_ready;
        pass_s     = condPass(condCode, psr);
        isCmp_s    = (opCode1 == 4'hB) || ((opCode1 == 4'h0) && (opCode2 == 4'hB));
        boundary_s = halt ? HALT : FETCH;
    end

    // State sequencing and memory wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= FETCH;
            waitCnt_r <= '0;
        end else begin
            if (memPhase_s && !mem_ready) begin
                waitCnt_r <= waitCnt_r + TCNT_BITS'(1);
            end else begin
                waitCnt_r <= '0;
            end
            case (state_r)
                FETCH: begin
                    if (mem_ready)      state_r <= DECODE;
                    else if (timeout_s) state_r <= FAULT;
                    else                state_r <= FETCH;
                end
                DECODE: begin
                    case (opCode1)
                        4'h0:                                    state_r <= RTYPEEX;
                        4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD: state_r <= ITYPEEX;
                        4'h8, 4'hF:                              state_r <= SHIFTEX;
                        4'hC:                                    state_r <= BCONDEX;
                        4'h4:                                    state_r <= MEMADR;
                        default:                                 state_r <= FAULT;
                    endcase
                end
                ITYPEEX, RTYPEEX, SHIFTEX: state_r <= ALUWR;
                MEMADR: begin
                    case (opCode2)
                        4'h0:    state_r <= LDRD;
                        4'h4:    state_r <= STWR;
                        4'h8:    state_r <= JALEX;
                        4'hC:    state_r <= JCONDEX;
                        default: state_r <= FAULT;
                    endcase
                end
                LDRD: begin
                    if (mem_ready)      state_r <= LDWR;
                    else if (timeout_s) state_r <= FAULT;
                    else                state_r <= LDRD;
                end
                STWR: begin
                    if (mem_ready)      state_r <= boundary_s;
                    else if (timeout_s) state_r <= FAULT;
                    else                state_r <= STWR;
                end
                JALEX:                                   state_r <= JALWR;
                ALUWR, LDWR, JALWR, BCONDEX, JCONDEX:    state_r <= boundary_s;
                HALT: begin
                    if (halt) state_r <= HALT;
                    else      state_r <= FETCH;
                end
                FAULT:   state_r <= FAULT;
                default: state_r <= FAULT;
            endcase
        end
    end

    // Datapath strobes; handshake-qualified strobes follow mem_ready in the same cycle.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_load    = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'd0;
        alu_ctrl   = 4'h0;
        shift_ctrl = 4'h0;
        srcb_imm   = 1'b0;
        zero_ext   = 1'b0;
        result_sel = 2'd0;
        result_en  = 1'b0;
        psr_en     = 1'b0;
        reg_we     = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;
        state_o    = 5'd0;
        if (reset) begin
            state_o = 5'd0;
        end else begin
            state_o = state_r;
            case (state_r)
                FETCH: begin
                    mem_req = 1'b1;
                    ir_load = mem_ready;
                    pc_en   = mem_ready;
                end
                ITYPEEX: begin
                    alu_ctrl   = opCode1;
                    srcb_imm   = 1'b1;
                    zero_ext   = opCode1 inside {4'h1, 4'h2, 4'h3, 4'hD};
                    result_sel = 2'd1;
                    result_en  = 1'b1;
                    psr_en     = 1'b1;
                end
                RTYPEEX: begin
                    alu_ctrl   = opCode2;
                    result_sel = 2'd1;
                    result_en  = 1'b1;
                    psr_en     = 1'b1;
                end
                SHIFTEX: begin
                    shift_ctrl = (opCode1 == 4'hF) ? 4'hF : opCode2;
                    srcb_imm   = (opCode1 == 4'hF) || (opCode2 != 4'h4);
                    result_en  = 1'b1;
                end
                ALUWR: begin
                    reg_we     = !isCmp_s;
                    instr_done = 1'b1;
                end
                LDRD: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                end
                LDWR: begin
                    result_sel = 2'd2;
                    reg_we     = 1'b1;
                    instr_done = 1'b1;
                end
                STWR: begin
                    mem_req    = 1'b1;
                    addr_sel   = 1'b1;
                    mem_we     = 1'b1;
                    instr_done = mem_ready;
                end
                BCONDEX: begin
                    pc_src     = 2'd1;
                    pc_en      = pass_s;
                    instr_done = 1'b1;
                end
                JALEX: begin
                    result_sel = 2'd3;
                    result_en  = 1'b1;
                    pc_src     = 2'd2;
                    pc_en      = 1'b1;
                end
                JALWR: begin
                    reg_we     = 1'b1;
                    instr_done = 1'b1;
                end
                JCONDEX: begin
                    pc_src     = 2'd2;
                    pc_en      = pass_s;
                    instr_done = 1'b1;
                end
                HALT:           halted  = 1'b1;
                DECODE, MEMADR: state_o = state_r;
                default:        fault   = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized bench for mc_control_unit: a per-instruction planner expands each instruction
// into its expected cycle trace, which is then replayed against the DUT cycle by cycle.
module tb_mc_control_unit;

    localparam int WDOG = 15;

    logic       clk = 1'b0;
    logic       reset, mem_ready, halt;
    logic [3:0] opCode1, opCode2, condCode;
    logic [4:0] psr;
    logic       mem_req, mem_we, addr_sel, ir_load, pc_en;
    logic [1:0] pc_src, result_sel;
    logic [3:0] alu_ctrl, shift_ctrl;
    logic       srcb_imm, zero_ext, result_en, psr_en, reg_we, instr_done, halted, fault;
    logic [4:0] state_o;

    always #5 clk = ~clk;

    mc_control_unit dut (
        .clk(clk), .reset(reset), .opCode1(opCode1), .opCode2(opCode2), .condCode(condCode),
        .psr(psr), .mem_ready(mem_ready), .halt(halt), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .ir_load(ir_load), .pc_en(pc_en), .pc_src(pc_src),
        .alu_ctrl(alu_ctrl), .shift_ctrl(shift_ctrl), .srcb_imm(srcb_imm), .zero_ext(zero_ext),
        .result_sel(result_sel), .result_en(result_en), .psr_en(psr_en), .reg_we(reg_we),
        .instr_done(instr_done), .halted(halted), .fault(fault), .state_o(state_o)
    );

    typedef struct packed {
        logic [4:0] st;
        logic       memReq, memWe, addrSel, irLoad, pcEn;
        logic [1:0] pcSrc;
        logic [3:0] alu, shf;
        logic       srcbImm, zeroExt;
        logic [1:0] resSel;
        logic       resEn, psrEn, regWe, done, halted, fault;
    } outs_t;

    typedef struct packed {
        logic       rst, rdy, hlt;
        logic [3:0] op1, op2, cc;
        logic [4:0] psr;
        outs_t      exp;
    } cyc_t;

    cyc_t       plan[$];
    logic [3:0] cOp1 = 4'h0, cOp2 = 4'h0, cCc = 4'h0;
    logic [4:0] cPsr = 5'h00;
    int         nTests = 0;
    int         nFail  = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic outs_t idle(input logic [4:0] st);
        outs_t o;
        o = '0;
        o.st = st;
        return o;
    endfunction

    // Branch condition: pairs of codes are a base condition and its negation.
    function automatic logic passRef(input logic [3:0] cc, input logic [4:0] p);
        logic z, c, f, l, n, base;
        z = p[4]; c = p[3]; f = p[2]; l = p[1]; n = p[0];
        case (cc[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = l;
            3'd4:    base = f;
            3'd5:    base = !z && !n;
            3'd6:    base = !l && !z;
            default: base = 1'b1;
        endcase
        return cc[0] ? !base : base;
    endfunction

    task automatic push(input outs_t o, input logic rdy, input logic hlt);
        cyc_t c;
        c.rst = 1'b0; c.rdy = rdy; c.hlt = hlt;
        c.op1 = cOp1; c.op2 = cOp2; c.cc = cCc; c.psr = cPsr; c.exp = o;
        plan.push_back(c);
    endtask

    task automatic pushReset(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c.rst = 1'b1; c.rdy = rnd(); c.hlt = rnd();
            c.op1 = cOp1; c.op2 = cOp2; c.cc = cCc; c.psr = cPsr; c.exp = '0;
            plan.push_back(c);
        end
    endtask

    task automatic pushFault();
        outs_t o;
        o = idle(5'h0F);
        o.fault = 1'b1;
        for (int i = 0; i < 3; i++) push(o, rnd(), rnd());
        pushReset(2);
    endtask

    // Wait cycles of a memory request; the WDOG-th consecutive wait leads to FAULT.
    task automatic memWaits(input logic [4:0] st, input logic we, input logic aSel,
                            input int waits, output bit faulted);
        outs_t o;
        o = idle(st);
        o.memReq = 1'b1; o.memWe = we; o.addrSel = aSel;
        faulted = 1'b0;
        for (int i = 0; i < waits && !faulted; i++) begin
            push(o, 1'b0, rnd());
            if (i + 1 == WDOG) faulted = 1'b1;
        end
        if (faulted) pushFault();
    endtask

    task automatic pushDone(input outs_t o, input logic rdy, input bit doHalt, input int hCyc);
        outs_t h;
        o.done = 1'b1;
        push(o, rdy, doHalt);
        if (doHalt) begin
            h = idle(5'h0E);
            h.halted = 1'b1;
            for (int i = 0; i < hCyc; i++) push(h, rnd(), 1'b1);
            push(h, rnd(), 1'b0);
        end
    endtask

    task automatic planInstr(input logic [3:0] op1, input logic [3:0] op2, input logic [3:0] cc,
                             input logic [4:0] ps, input int wF, input int wM,
                             input bit doHalt, input int hCyc);
        outs_t o;
        bit    f;
        cOp1 = op1; cOp2 = op2; cCc = cc; cPsr = ps;
        memWaits(5'h00, 1'b0, 1'b0, wF, f);
        if (f) return;
        o = idle(5'h00); o.memReq = 1'b1; o.irLoad = 1'b1; o.pcEn = 1'b1;
        push(o, 1'b1, rnd());
        push(idle(5'h01), rnd(), rnd());
        if (op1 == 4'h0) begin
            o = idle(5'h03); o.alu = op2; o.resSel = 2'd1; o.resEn = 1'b1; o.psrEn = 1'b1;
            push(o, rnd(), rnd());
            o = idle(5'h05); o.regWe = (op2 != 4'hB);
            pushDone(o, rnd(), doHalt, hCyc);
        end else if (op1 inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD}) begin
            o = idle(5'h02); o.alu = op1; o.srcbImm = 1'b1;
            o.zeroExt = (op1 inside {4'h1, 4'h2, 4'h3, 4'hD});
            o.resSel = 2'd1; o.resEn = 1'b1; o.psrEn = 1'b1;
            push(o, rnd(), rnd());
            o = idle(5'h05); o.regWe = (op1 != 4'hB);
            pushDone(o, rnd(), doHalt, hCyc);
        end else if (op1 == 4'h8 || op1 == 4'hF) begin
            o = idle(5'h04); o.resEn = 1'b1;
            o.shf = (op1 == 4'hF) ? 4'hF : op2;
            o.srcbImm = (op1 == 4'hF) || (op2 != 4'h4);
            push(o, rnd(), rnd());
            o = idle(5'h05); o.regWe = 1'b1;
            pushDone(o, rnd(), doHalt, hCyc);
        end else if (op1 == 4'hC) begin
            o = idle(5'h0A); o.pcSrc = 2'd1; o.pcEn = passRef(cc, ps);
            pushDone(o, rnd(), doHalt, hCyc);
        end else if (op1 == 4'h4) begin
            push(idle(5'h06), rnd(), rnd());
            if (op2 == 4'h0) begin
                memWaits(5'h07, 1'b0, 1'b1, wM, f);
                if (f) return;
                o = idle(5'h07); o.memReq = 1'b1; o.addrSel = 1'b1;
                push(o, 1'b1, rnd());
                o = idle(5'h08); o.resSel = 2'd2; o.regWe = 1'b1;
                pushDone(o, rnd(), doHalt, hCyc);
            end else if (op2 == 4'h4) begin
                memWaits(5'h09, 1'b1, 1'b1, wM, f);
                if (f) return;
                o = idle(5'h09); o.memReq = 1'b1; o.memWe = 1'b1; o.addrSel = 1'b1;
                pushDone(o, 1'b1, doHalt, hCyc);
            end else if (op2 == 4'h8) begin
                o = idle(5'h0B); o.resSel = 2'd3; o.resEn = 1'b1; o.pcSrc = 2'd2; o.pcEn = 1'b1;
                push(o, rnd(), rnd());
                o = idle(5'h0C); o.regWe = 1'b1;
                pushDone(o, rnd(), doHalt, hCyc);
            end else if (op2 == 4'hC) begin
                o = idle(5'h0D); o.pcSrc = 2'd2; o.pcEn = passRef(cc, ps);
                pushDone(o, rnd(), doHalt, hCyc);
            end else begin
                pushFault();
            end
        end else begin
            pushFault();
        end
    endtask

    // Fetch abandoned part-way through its wait by a reset.
    task automatic planAbort(input int k);
        bit f;
        memWaits(5'h00, 1'b0, 1'b0, k, f);
        if (!f) pushReset(1);
    endtask

    initial begin
        logic [4:0] psrPat[4];
        logic [3:0] r1, r2;
        outs_t      got;
        int         wF, wM;

        psrPat[0] = 5'b10000; psrPat[1] = 5'b00010; psrPat[2] = 5'b00001; psrPat[3] = 5'b00000;
        reset = 1'b1; mem_ready = 1'b0; halt = 1'b0;
        opCode1 = 4'h0; opCode2 = 4'h0; condCode = 4'h0; psr = 5'h00;

        pushReset(2);
        planInstr(4'h5, 4'h0, 4'h0, 5'h00, 0, 0, 1'b0, 0);
        planInstr(4'h4, 4'h0, 4'h0, 5'h00, 0, 3, 1'b0, 0);
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 16; c++)
                planInstr(4'hC, 4'h0, 4'(c), psrPat[p], 0, 0, 1'b0, 0);
        planInstr(4'h0, 4'h0, 4'h0, 5'h00, WDOG, 0, 1'b0, 0);
        planInstr(4'h0, 4'hB, 4'h0, 5'h00, 1, 0, 1'b1, 2);
        planInstr(4'h6, 4'h0, 4'h0, 5'h00, 0, 0, 1'b0, 0);
        planInstr(4'h4, 4'h4, 4'h0, 5'h00, 2, WDOG, 1'b0, 0);
        planAbort(9);
        planInstr(4'h4, 4'h8, 4'h0, 5'h00, 0, 0, 1'b1, 0);
        planInstr(4'h4, 4'hC, 4'hE, 5'h00, 0, 0, 1'b0, 0);
        planInstr(4'h4, 4'h3, 4'h0, 5'h00, 0, 0, 1'b0, 0);
        for (int n = 0; n < 120; n++) begin
            r1 = 4'($urandom_range(0, 15));
            r2 = 4'($urandom_range(0, 15));
            if (r1 == 4'h4 && $urandom_range(0, 7) != 0) r2 = {2'($urandom_range(0, 3)), 2'b00};
            wF = ($urandom_range(0, 29) == 0) ? WDOG : int'($urandom_range(0, 3));
            wM = ($urandom_range(0, 29) == 0) ? WDOG : int'($urandom_range(0, 3));
            planInstr(r1, r2, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), wF, wM,
                      ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
        end

        for (int i = 0; i < plan.size(); i++) begin
            reset = plan[i].rst; mem_ready = plan[i].rdy; halt = plan[i].hlt;
            opCode1 = plan[i].op1; opCode2 = plan[i].op2; condCode = plan[i].cc; psr = plan[i].psr;
            @(negedge clk);
            got = {state_o, mem_req, mem_we, addr_sel, ir_load, pc_en, pc_src, alu_ctrl,
                   shift_ctrl, srcb_imm, zero_ext, result_sel, result_en, psr_en, reg_we,
                   instr_done, halted, fault};
            checkVal($sformatf("cyc%0d_st%0h", i, plan[i].exp.st), {2'b00, got}, {2'b00, plan[i].exp});
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
